// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC generation, single-outstanding memory
// read, small instruction FIFO toward decode, stall and redirect handling.
//
// Optional feature macro: FETCH_RESP_BYPASS_EN
//   When defined, a response arriving while the FIFO is empty (and no redirect is
//   active) is forwarded combinationally to decode in the same cycle.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   mem_req_valid     read request valid
//   mem_req_addr      read address (word aligned)
//   mem_req_ready     memory accepts the request this cycle
//   mem_resp_valid    read data valid
//   mem_resp_data     instruction word
//   IDIF_stall        decode cannot accept this cycle
//   EXIF_branch       redirect request from execute
//   EXIF_target       redirect PC
//   IFID_instreg      head instruction, NOP when empty
//   IFID_npc          PC+4 of head instruction, 0 when empty
//   IFID_ready        an instruction is available for decode
module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        IDIF_stall,
  input  logic        EXIF_branch,
  input  logic [63:0] EXIF_target,
  output logic [31:0] IFID_instreg,
  output logic [63:0] IFID_npc,
  output logic        IFID_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t            state, state_nx;
  logic [63:0]       fetch_pc;
  logic [31:0]       fifo_inst [FIFO_DEPTH];
  logic [63:0]       fifo_npc  [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic fifo_empty, fifo_has_room;
  logic req_fire, resp_live, bypass_take, push, pop;
  logic unused_target_lsbs;

  assign unused_target_lsbs = ^EXIF_target[1:0];

  assign fifo_empty    = (count == '0);
  assign fifo_has_room = (count < CNT_W'(FIFO_DEPTH));
  assign req_fire      = mem_req_valid && mem_req_ready;
  // A response that belongs to the current fetch stream and survives this cycle.
  assign resp_live     = (state == S_WAIT) && mem_resp_valid && !EXIF_branch;

`ifdef FETCH_RESP_BYPASS_EN
  assign bypass_take = resp_live && fifo_empty && !IDIF_stall;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = resp_live && !bypass_take;
  assign pop  = !fifo_empty && !IDIF_stall && !EXIF_branch;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_nx;
  end

  // Next-state logic; a redirect turns any still-outstanding request stale
  always_comb begin
    state_nx = state;
    case (state)
      S_REQ:  if (req_fire) state_nx = EXIF_branch ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (mem_resp_valid)   state_nx = S_REQ;
        else if (EXIF_branch) state_nx = S_DROP;
      end
      S_DROP: if (mem_resp_valid) state_nx = S_REQ;
      default: state_nx = S_REQ;
    endcase
  end

  // Memory request outputs
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = fetch_pc;
    if (!reset && (state == S_REQ) && fifo_has_room) mem_req_valid = 1'b1;
  end

  // Decode-facing outputs: FIFO head, or the bypassed response when enabled
  always_comb begin
    IFID_ready   = 1'b0;
    IFID_instreg = NOP;
    IFID_npc     = '0;
    if (!reset) begin
      if (!fifo_empty) begin
        IFID_ready   = 1'b1;
        IFID_instreg = fifo_inst[rd_ptr];
        IFID_npc     = fifo_npc[rd_ptr];
      end
`ifdef FETCH_RESP_BYPASS_EN
      else if (resp_live) begin
        IFID_ready   = 1'b1;
        IFID_instreg = mem_resp_data;
        IFID_npc     = fetch_pc;
      end
`endif
    end
  end

  // PC and FIFO bookkeeping; redirect flushes and overrides push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= {RESET_PC[63:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (EXIF_branch) begin
      fetch_pc <= {EXIF_target[63:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 64'd4;
      if (push)     wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr   <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; in WAIT fetch_pc already holds the outstanding address + 4
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_inst[wr_ptr] <= mem_resp_data;
      fifo_npc[wr_ptr]  <= fetch_pc;
    end
  end

endmodule
